// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state encodings and the step-counter width helper.
package seq_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A one-bit counter is still needed when SIZE is small enough that clog2 collapses to zero.
   function automatic int cnt_width(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// Parameterised ripple-carry adder used for the partial-product accumulate step.
// Produces SIZE sum bits plus the carry out of the top bit.
module seq_multiplier_adder #(
   parameter int SIZE = 4
) (
   output logic            c_out,
   output logic [SIZE-1:0] sum,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            c_in
);

   logic [SIZE:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < SIZE; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[SIZE];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned sequential shift-add multiplier: one partial product per RUN cycle,
// result registered on the final step and held until the next accepted start.
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   output logic              busy,
   output logic              done,
   output logic [2*SIZE-1:0] product
);

   localparam int CW = cnt_width(SIZE);
   localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

   state_t state;
   state_t state_next;

   logic [SIZE-1:0]   mcand;
   logic [SIZE-1:0]   hi;
   logic [SIZE-1:0]   lo;
   logic [CW-1:0]     cnt;

   logic              load;
   logic              step;
   logic              last_step;

   logic              add_c;
   logic [SIZE-1:0]   add_s;
   logic              shift_c;
   logic [SIZE-1:0]   shift_s;
   logic [2*SIZE-1:0] acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      last_step  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               last_step  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   seq_multiplier_adder #(
      .SIZE (SIZE)
   ) u_adder (
      .c_out (add_c),
      .sum   (add_s),
      .a     (hi),
      .b     (mcand),
      .c_in  (1'b0)
   );

   // Keeping the adder carry as the new top bit is what makes the result exact for all operands.
   always_comb begin
      shift_c = 1'b0;
      shift_s = hi;
      if (lo[0]) begin
         shift_c = add_c;
         shift_s = add_s;
      end
   end

   assign acc_next = {shift_c, shift_s, lo[SIZE-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         mcand <= a;
         hi    <= '0;
         lo    <= b;
         cnt   <= '0;
      end else if (step) begin
         {hi, lo} <= acc_next;
         // The counter parks at its final value rather than wrapping past it.
         if (!last_step) begin
            cnt <= cnt + CW'(1);
         end
         if (last_step) begin
            product <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at SIZE=4.
// Expected products and latencies are hand-computed constants or a*b.
module tb_seq_multiplier;

   localparam int SIZE = 4;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [SIZE-1:0]   a     = '0;
   logic [SIZE-1:0]   b     = '0;
   logic              busy;
   logic              done;
   logic [2*SIZE-1:0] product;

   int errors    = 0;
   int checks    = 0;
   int doneCount = 0;

   seq_multiplier #(
      .SIZE (SIZE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
      @(negedge clk);
      start = s;
      a     = av;
      b     = bv;
   endtask

   // Issues one start pulse and waits (bounded) for done; lat counts negedges after acceptance.
   task automatic runOp(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                        output int lat, output logic [2*SIZE-1:0] prod, output logic busyFirst);
      applyStimulus(1'b1, av, bv);
      @(negedge clk);
      start     = 1'b0;
      busyFirst = busy;
      lat       = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      prod = product;
   endtask

   initial begin
      int                lat;
      logic [2*SIZE-1:0] prod;
      logic              busyFirst;
      int                d0;
      int                seen;
      int                doneAt [3];
      logic [2*SIZE-1:0] prodAt [3];

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_product", 32'(product), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // 15*15 with latency, busy and single-cycle done
      runOp(4'd15, 4'd15, lat, prod, busyFirst);
      checkOutput("max_busy_run", 32'(busyFirst), 32'd1);
      checkOutput("max_latency", 32'(lat), 32'd5);
      checkOutput("max_product", 32'(prod), 32'd225);
      checkOutput("max_busy_done", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("done_width", 32'(done), 32'd0);
      checkOutput("product_hold", 32'(product), 32'd225);

      // Directed vectors including zero operands
      runOp(4'd13, 4'd11, lat, prod, busyFirst);
      checkOutput("p13x11", 32'(prod), 32'd143);
      runOp(4'd0, 4'd9, lat, prod, busyFirst);
      checkOutput("p0x9", 32'(prod), 32'd0);
      runOp(4'd7, 4'd0, lat, prod, busyFirst);
      checkOutput("p7x0", 32'(prod), 32'd0);
      checkOutput("p7x0_latency", 32'(lat), 32'd5);

      // Second start during RUN must be ignored and operand changes must not leak in
      #1 d0 = doneCount;
      applyStimulus(1'b1, 4'd3, 4'd5);
      @(negedge clk);
      start = 1'b0;
      applyStimulus(1'b1, 4'd15, 4'd15);
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("ignore_latency", 32'(lat), 32'd5);
      checkOutput("ignore_product", 32'(product), 32'd15);
      repeat (8) @(negedge clk);
      #1 checkOutput("ignore_one_done", 32'(doneCount - d0), 32'd1);

      // Reset in the second RUN cycle aborts with no done pulse
      #1 d0 = doneCount;
      applyStimulus(1'b1, 4'd9, 4'd7);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_product", 32'(product), 32'd0);
      repeat (6) @(negedge clk);
      #1 checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      runOp(4'd2, 4'd3, lat, prod, busyFirst);
      checkOutput("after_abort_latency", 32'(lat), 32'd5);
      checkOutput("after_abort_product", 32'(prod), 32'd6);
      checkOutput("after_abort_no_done", 32'(doneCount - d0), 32'd0);

      // Start held high: three operations at a 6-cycle period
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         doneAt[k] = 0;
         prodAt[k] = '0;
      end
      applyStimulus(1'b1, 4'd5, 4'd6);
      for (int cyc = 1; cyc <= 40 && seen < 3; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            doneAt[seen] = cyc;
            prodAt[seen] = product;
            seen++;
            if (seen == 1) begin
               a = 4'd9;
               b = 4'd14;
            end else if (seen == 2) begin
               a = 4'd12;
               b = 4'd12;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      checkOutput("held_count", 32'(seen), 32'd3);
      checkOutput("held_first_at", 32'(doneAt[0]), 32'd5);
      checkOutput("held_gap1", 32'(doneAt[1] - doneAt[0]), 32'd6);
      checkOutput("held_gap2", 32'(doneAt[2] - doneAt[1]), 32'd6);
      checkOutput("held_p0", 32'(prodAt[0]), 32'd30);
      checkOutput("held_p1", 32'(prodAt[1]), 32'd126);
      checkOutput("held_p2", 32'(prodAt[2]), 32'd144);
      repeat (2) @(negedge clk);

      // Exhaustive sweep
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            runOp(SIZE'(i), SIZE'(j), lat, prod, busyFirst);
            checkOutput($sformatf("sweep_%0dx%0d", i, j), 32'(prod), 32'(i * j));
            checkOutput($sformatf("sweep_lat_%0dx%0d", i, j), 32'(lat), 32'd5);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL take parameter SIZE, default 4, the operand width in bits, with legal range 2..16.
REQ-002 clk  input  1  The block SHALL use clk as its single clock and SHALL sample all state on its rising edge.
REQ-003 rst_n  input  1  rst_n SHALL be an asynchronous, active-low reset.
REQ-004 start  input  1  A high start in IDLE SHALL request one multiplication.
REQ-005 a  input  SIZE  a SHALL be the unsigned multiplicand, sampled only when start is accepted.
REQ-006 b  input  SIZE  b SHALL be the unsigned multiplier, sampled only when start is accepted.
REQ-007 busy  output  1  busy SHALL be high while the FSM is in RUN.
REQ-008 done  output  1  done SHALL be a one-cycle pulse, high while the FSM is in DONE.
REQ-009 product  output  2*SIZE  product SHALL be the registered result, valid from the done cycle until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 IDLE SHALL go to RUN on start=1, and SHALL otherwise stay in IDLE.
REQ-012 RUN SHALL go to DONE when the step counter reaches SIZE-1, and SHALL otherwise stay in RUN.
REQ-013 DONE SHALL go unconditionally to IDLE after one cycle.
REQ-014 On accepted start: mcand<=a, hi<=0, lo<=b, cnt<=0.
REQ-015 Each RUN cycle, {c,s} SHALL equal hi+mcand (c_in=0) if lo[0]=1, and SHALL equal {0,hi} otherwise.
REQ-016 Each RUN cycle SHALL then shift right: {hi,lo}<={c,s,lo[SIZE-1:1]}, and cnt SHALL increment.
REQ-017 The shift SHALL retain the adder carry-out, so no result bit is lost; product SHALL equal a*b exactly for all operand values.
REQ-018 Latency SHALL be as follows: start sampled at edge k, RUN on edges k+1..k+SIZE, done high in the cycle following edge k+SIZE, i.e. SIZE+1 cycles after start.
REQ-019 product SHALL be updated to {hi,lo} on the RUN->DONE edge, and SHALL be held otherwise.
REQ-020 A start asserted in RUN or DONE SHALL be ignored; mcand, hi, lo and cnt SHALL NOT change and no second operation SHALL be queued.
REQ-021 A start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE (back-to-back period SIZE+2 cycles).
REQ-022 A change on a or b after acceptance SHALL have no effect on the current operation.
REQ-023 cnt SHALL be clog2(SIZE) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=0, mcand=0, hi=0, lo=0 and cnt=0, independent of clk.
REQ-025 A reset asserted mid-operation SHALL abort it with no done pulse; product SHALL read 0 afterwards.
REQ-026 After rst_n deasserts, a start SHALL be accepted on the first rising edge.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared team package/header; SIZE stays a module parameter.
REQ-028 The add SHALL be performed by one instance of the team's existing parameterised ripple adder, with ports c_out, sum, a, b, c_in and parameter SIZE, using c_in tied to 0.
REQ-029 The FSM, counter and shift register SHALL be in seq_multiplier, with no other sub-modules.
REQ-030 Unused state encoding 2'd3 SHALL return to IDLE.

Verification
REQ-031 SIZE=4, a=15, b=15, single start: the bench SHALL check done exactly 5 cycles later and product=225.
REQ-032 SIZE=4, a=13, b=11 -> product=143; then a=0, b=9 -> product=0; then a=7, b=0 -> product=0.
REQ-033 SIZE=4, start at cycle 0 with a=3, b=5, then start pulsed again at cycle 2 with a=15, b=15: the bench SHALL check that the second start is ignored, product=15, and exactly one done pulse.
REQ-034 SIZE=4, rst_n pulled low at cycle 2 of RUN: the bench SHALL check busy=0, done never asserted, product=0, and that a following start with a=2, b=3 gives product=6.
REQ-035 SIZE=4, start held high for 3 operations: the bench SHALL check done pulses spaced 6 cycles apart with correct products each time.
REQ-036 SIZE=4 exhaustive sweep of {a,b} (256 cases): the bench SHALL check product==a*b on every done pulse.
